// File: rtl/wash_program_sequencer.sv
// wash_program_sequencer: wash program phase sequencer driving the shared multi-phase timer.
// Optional phase watchdog enabled by defining SEQ_WATCHDOG_EN.
module wash_program_sequencer #(
    parameter int LOCK_DELAY   = 4,
    parameter int DRAIN_CYCLES = 8,
    parameter int WDOG_LIMIT   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cancel,
    input  logic       lid,
    input  logic [1:0] mode,
    input  logic [1:0] rinse_cnt,
    input  logic       timer_done,
    output logic [1:0] phase_sel,
    output logic       timer_start,
    output logic       timer_enable,
    output logic       door_lock,
    output logic       drain_valve,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOCK, S_SOAK, S_WASH, S_RINSE, S_SPIN, S_PAUSE, S_DRAIN, S_DONE
    } state_t;

    state_t      state_q, state_d, ret_q, ret_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d, mode_q, mode_d, rinse_q, rinse_d, phase_sel_q, phase_sel_d;
    logic        error_q, error_d, timer_start_q, timer_start_d, timer_enable_q, timer_enable_d;
    logic        door_lock_q, door_lock_d, drain_valve_q, drain_valve_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        entry, in_phase, wd_trip, abort, quick, heavy;
    logic [1:0]  rinse_total;

    assign in_phase    = state_q inside {[S_SOAK:S_SPIN]};
    assign abort       = cancel || wd_trip;
    assign quick       = mode_q == 2'b00;
    assign heavy       = mode_q == 2'b10;
    assign rinse_total = heavy ? ((rinse_q == 2'd0) ? 2'd1 : rinse_q) : 2'd1;

`ifdef SEQ_WATCHDOG_EN
    logic [31:0] wd_q, wd_d;
    assign wd_trip = in_phase && !timer_done && (wd_q >= 32'(WDOG_LIMIT));
    assign wd_d    = timer_start_d ? 32'd0 : wd_q + 32'(timer_enable_q);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wd_q <= '0;
        else        wd_q <= wd_d;
`else
    localparam int unused_wdog_limit = WDOG_LIMIT;
    assign wd_trip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        rinse_d = rinse_q;
        error_d = error_q | wd_trip;
        entry   = 1'b0;
        unique case (state_q)
            S_IDLE: if (start && !lid) begin
                state_d = S_LOCK;
                mode_d  = mode;
                rinse_d = rinse_cnt;
                error_d = 1'b0;
            end
            S_LOCK:
                if (abort)      state_d = S_DRAIN;
                else if (lid)   state_d = S_IDLE;
                else if (cnt_q >= 16'(LOCK_DELAY - 1)) begin
                    state_d = quick ? S_WASH : S_SOAK;
                    entry   = 1'b1;
                end
            S_SOAK, S_WASH, S_RINSE, S_SPIN:
                if (abort) state_d = S_DRAIN;
                else if (lid) begin
                    state_d = S_PAUSE;
                    ret_d   = state_q;
                end else if (timer_done) begin
                    entry = 1'b1;
                    // Each rinse repeat re-enters RINSE so the timer reloads
                    if (state_q == S_SOAK)      state_d = S_WASH;
                    else if (state_q == S_WASH) begin
                        state_d = quick ? S_SPIN : S_RINSE;
                        idx_d   = 2'd1;
                    end else if (state_q == S_RINSE && idx_q < rinse_total) begin
                        state_d = S_RINSE;
                        idx_d   = idx_q + 2'd1;
                    end else if (state_q == S_RINSE) state_d = S_SPIN;
                    else begin
                        state_d = S_DONE;
                        entry   = 1'b0;
                    end
                end
            S_PAUSE:
                if (abort)     state_d = S_DRAIN;
                else if (!lid) state_d = ret_q;
            S_DRAIN: if (cnt_q >= 16'(DRAIN_CYCLES - 1)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        cnt_d          = (state_d != state_q) ? 16'd0 : cnt_q + 16'(cnt_q != 16'hffff);
        timer_start_d  = entry;
        phase_sel_d    = entry ? 2'(state_d - S_SOAK) : phase_sel_q;
        timer_enable_d = state_d inside {[S_SOAK:S_SPIN]};
        door_lock_d    = state_d inside {[S_LOCK:S_DRAIN]};
        drain_valve_d  = state_d == S_DRAIN;
        busy_d         = state_d != S_IDLE;
        done_d         = state_d == S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ret_q          <= S_IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            mode_q         <= '0;
            rinse_q        <= '0;
            error_q        <= 1'b0;
            phase_sel_q    <= '0;
            timer_start_q  <= 1'b0;
            timer_enable_q <= 1'b0;
            door_lock_q    <= 1'b0;
            drain_valve_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ret_q          <= ret_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            mode_q         <= mode_d;
            rinse_q        <= rinse_d;
            error_q        <= error_d;
            phase_sel_q    <= phase_sel_d;
            timer_start_q  <= timer_start_d;
            timer_enable_q <= timer_enable_d;
            door_lock_q    <= door_lock_d;
            drain_valve_q  <= drain_valve_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign state        = state_q;
    assign phase_sel    = phase_sel_q;
    assign timer_start  = timer_start_q;
    assign timer_enable = timer_enable_q;
    assign door_lock    = door_lock_q;
    assign drain_valve  = drain_valve_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
endmodule

// File: tb/tb_wash_program_sequencer.sv
// tb_wash_program_sequencer: directed vectors for the wash program sequencer.
module tb_wash_program_sequencer;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       start = 1'b0, cancel = 1'b0, lid = 1'b0, timer_done = 1'b0;
    logic [1:0] mode = 2'b00, rinse_cnt = 2'b00;
    logic [1:0] phase_sel;
    logic       timer_start, timer_enable, door_lock, drain_valve, busy, done, error;
    logic [3:0] state;
    int         vectors = 0, errs = 0;

    wash_program_sequencer #(.LOCK_DELAY(4), .DRAIN_CYCLES(8), .WDOG_LIMIT(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel), .lid(lid), .mode(mode),
        .rinse_cnt(rinse_cnt), .timer_done(timer_done), .phase_sel(phase_sel),
        .timer_start(timer_start), .timer_enable(timer_enable), .door_lock(door_lock),
        .drain_valve(drain_valve), .busy(busy), .done(done), .error(error), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic begin_prog(input logic [1:0] m, input logic [1:0] r);
        mode = m; rinse_cnt = r; start = 1'b1;
        tick();
        start = 1'b0;
        chk("lock_state", state, 4'd1);
        ticks(4);
    endtask

    task automatic phase(input string tag, input logic [3:0] s, input logic [1:0] sel, input int len);
        chk({tag, "_state"}, state, s);
        chk({tag, "_tstart"}, {3'b0, timer_start}, 4'd1);
        chk({tag, "_sel"}, {2'b0, phase_sel}, {2'b0, sel});
        chk({tag, "_en"}, {3'b0, timer_enable}, 4'd1);
        tick();
        chk({tag, "_tstart_off"}, {3'b0, timer_start}, 4'd0);
        chk({tag, "_lock"}, {3'b0, door_lock}, 4'd1);
        ticks(len - 2);
        timer_done = 1'b1;
        tick();
        timer_done = 1'b0;
    endtask

    task automatic finish_done(input string tag);
        chk({tag, "_done_state"}, state, 4'd8);
        chk({tag, "_done_pulse"}, {3'b0, done}, 4'd1);
        chk({tag, "_done_unlock"}, {3'b0, door_lock}, 4'd0);
        tick();
        chk({tag, "_idle"}, state, 4'd0);
        chk({tag, "_done_off"}, {3'b0, done}, 4'd0);
        chk({tag, "_busy_off"}, {3'b0, busy}, 4'd0);
    endtask

    initial begin
        #12;
        chk("rst_state", state, 4'd0);
        chk("rst_outs", {busy, door_lock, timer_enable, timer_start}, 4'd0);
        chk("rst_outs2", {done, drain_valve, error, 1'b0}, 4'd0);
        rst_n = 1'b1;
        tick();
        // normal program
        mode = 2'b01; start = 1'b1;
        tick();
        start = 1'b0;
        chk("n_lock", state, 4'd1);
        chk("n_lock_door", {3'b0, door_lock}, 4'd1);
        chk("n_lock_busy", {3'b0, busy}, 4'd1);
        chk("n_lock_en", {3'b0, timer_enable}, 4'd0);
        ticks(3);
        chk("n_lock4", state, 4'd1);
        tick();
        phase("n_soak", 4'd2, 2'b00, 20);
        phase("n_wash", 4'd3, 2'b01, 20);
        phase("n_rinse", 4'd4, 2'b10, 20);
        phase("n_spin", 4'd5, 2'b11, 20);
        finish_done("n");
        chk("n_error", {3'b0, error}, 4'd0);
        // heavy, three rinses
        begin_prog(2'b10, 2'd3);
        phase("h3_soak", 4'd2, 2'b00, 5);
        phase("h3_wash", 4'd3, 2'b01, 5);
        phase("h3_rinse1", 4'd4, 2'b10, 5);
        phase("h3_rinse2", 4'd4, 2'b10, 5);
        phase("h3_rinse3", 4'd4, 2'b10, 5);
        phase("h3_spin", 4'd5, 2'b11, 5);
        finish_done("h3");
        // heavy, rinse_cnt 0 behaves as one rinse
        begin_prog(2'b10, 2'd0);
        phase("h0_soak", 4'd2, 2'b00, 5);
        phase("h0_wash", 4'd3, 2'b01, 5);
        phase("h0_rinse", 4'd4, 2'b10, 5);
        phase("h0_spin", 4'd5, 2'b11, 5);
        finish_done("h0");
        // quick program
        begin_prog(2'b00, 2'd0);
        phase("q_wash", 4'd3, 2'b01, 5);
        phase("q_spin", 4'd5, 2'b11, 5);
        finish_done("q");
        // lid pause mid-WASH, then cancel in RINSE
        begin_prog(2'b01, 2'd0);
        phase("p_soak", 4'd2, 2'b00, 5);
        chk("p_wash", state, 4'd3);
        ticks(3);
        lid = 1'b1;
        tick();
        chk("p_pause", state, 4'd6);
        chk("p_pause_en", {3'b0, timer_enable}, 4'd0);
        chk("p_pause_lock", {3'b0, door_lock}, 4'd1);
        chk("p_pause_sel", {2'b0, phase_sel}, 4'd1);
        ticks(4);
        timer_done = 1'b1;
        tick();
        timer_done = 1'b0;
        chk("p_pause_tdone", state, 4'd6);
        ticks(4);
        lid = 1'b0;
        tick();
        chk("p_resume", state, 4'd3);
        chk("p_resume_tstart", {3'b0, timer_start}, 4'd0);
        chk("p_resume_en", {3'b0, timer_enable}, 4'd1);
        ticks(2);
        timer_done = 1'b1;
        tick();
        timer_done = 1'b0;
        chk("c_rinse", state, 4'd4);
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("c_drain", state, 4'd7);
        chk("c_drain_valve", {3'b0, drain_valve}, 4'd1);
        chk("c_drain_en", {3'b0, timer_enable}, 4'd0);
        chk("c_drain_lock", {3'b0, door_lock}, 4'd1);
        ticks(7);
        chk("c_drain8", state, 4'd7);
        chk("c_drain8_valve", {3'b0, drain_valve}, 4'd1);
        tick();
        chk("c_valve_off", {3'b0, drain_valve}, 4'd0);
        finish_done("c");
        // cancel and lid together
        begin_prog(2'b01, 2'd0);
        cancel = 1'b1; lid = 1'b1;
        tick();
        cancel = 1'b0; lid = 1'b0;
        chk("cl_drain", state, 4'd7);
        ticks(8);
        finish_done("cl");
        // reset mid-SPIN
        begin_prog(2'b00, 2'd0);
        phase("r_wash", 4'd3, 2'b01, 5);
        chk("r_spin", state, 4'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("r_state", state, 4'd0);
        chk("r_outs", {busy, door_lock, timer_enable, timer_start}, 4'd0);
        chk("r_sel", {2'b0, phase_sel}, 4'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("r_stay", state, 4'd0);
        // start with lid open
        lid = 1'b1; start = 1'b1;
        ticks(3);
        chk("lid_start", state, 4'd0);
        start = 1'b0; lid = 1'b0;
        // lid during LOCK
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ll_lock", state, 4'd1);
        lid = 1'b1;
        tick();
        lid = 1'b0;
        chk("ll_idle", state, 4'd0);
        chk("ll_unlock", {3'b0, door_lock}, 4'd0);
`ifdef SEQ_WATCHDOG_EN
        begin_prog(2'b01, 2'd0);
        phase("w_soak", 4'd2, 2'b00, 5);
        chk("w_wash", state, 4'd3);
        ticks(64);
        chk("w_wash65", state, 4'd3);
        tick();
        chk("w_drain", state, 4'd7);
        chk("w_error", {3'b0, error}, 4'd1);
        ticks(8);
        finish_done("w");
        chk("w_error_sticky", {3'b0, error}, 4'd1);
        begin_prog(2'b01, 2'd0);
        chk("w_error_clear", {3'b0, error}, 4'd0);
`else
        chk("no_wdog_error", {3'b0, error}, 4'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/wash_program_sequencer.md
Name: wash_program_sequencer

Overview:
Program sequencer that owns the shared multi-phase timer for the washing machine datapath. It picks the phase list from the selected wash program and issues timer start and enable controls. It also handles the door lock, lid-open pause/resume, cancel-to-drain and the rinse repeat count. It sits between the user-input logic and the multi-phase timer and replaces ad-hoc sequencing inside the washing FSM.

Parameters:
LOCK_DELAY, 4, cycles door_lock must be held before the first phase starts (lock settle).
DRAIN_CYCLES, 8, cycles drain_valve is held after a cancel.
WDOG_LIMIT, 4096, max cycles in one phase without timer_done (used only with the optional feature).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level; sampled only in IDLE
cancel  input  1  level; abort the program
lid  input  1  1 = lid open
mode  input  2  00 quick, 01 normal, 10 heavy, 11 treated as normal
rinse_cnt  input  2  heavy-mode rinse repeats; 0 is treated as 1
timer_done  input  1  1-cycle pulse from the timer at the end of a phase
phase_sel  output  2  00 soak, 01 wash, 10 rinse, 11 spin
timer_start  output  1  1-cycle pulse that loads the timer for phase_sel
timer_enable  output  1  timer counts while high
door_lock  output  1  door lock solenoid
drain_valve  output  1  drain valve open
busy  output  1  high in every state except IDLE
done  output  1  1-cycle pulse on program completion or on the end of a cancel drain
error  output  1  sticky fault flag; cleared by the next accepted start
state  output  4  current state code

Behaviour:
- State codes: IDLE=0, LOCK=1, SOAK=2, WASH=3, RINSE=4, SPIN=5, PAUSE=6, DRAIN=7, DONE=8.
- Reset: state=IDLE. All outputs are 0. Internal counters are 0 and the saved return state is IDLE.
- Reset mid-program drops to IDLE at once. No resume on release.
- IDLE:
  - start=1 and lid=0: latch mode and rinse_cnt, clear error, go to LOCK.
  - start=1 and lid=1: ignored, stay in IDLE.
- LOCK:
  - door_lock=1.
  - After LOCK_DELAY cycles, go to the first phase of the program.
  - lid=1 during LOCK: go to IDLE and release door_lock.
- Phase lists:
  - quick: WASH, SPIN.
  - normal: SOAK, WASH, RINSE, SPIN.
  - heavy: SOAK, WASH, then RINSE repeated max(rinse_cnt,1) times, then SPIN.
- Phase entry:
  - phase_sel is set and timer_start pulses in the first cycle of the phase.
  - timer_enable is 1 from that same cycle for as long as the phase runs.
  - Each repeated RINSE is a fresh entry with a new timer_start pulse.
- Phase exit:
  - timer_done=1 moves to the next phase on the following edge.
  - timer_done in SPIN goes to DONE.
  - timer_done outside a phase state is ignored.
- PAUSE:
  - lid=1 in any phase state: go to PAUSE and save the return state and rinse index.
  - timer_enable=0; door_lock and phase_sel are held.
  - lid=0: return to the saved state with no timer_start pulse, so the timer resumes from its count.
  - A timer_done arriving while in PAUSE is ignored.
- DRAIN:
  - cancel=1 in any state other than IDLE, DRAIN or DONE: go to DRAIN.
  - drain_valve=1, timer_enable=0, door_lock=1.
  - After DRAIN_CYCLES cycles, go to DONE.
- DONE:
  - Lasts one cycle: done=1, door_lock=0, then go to IDLE.
- Same-cycle priority: reset > cancel > lid > timer_done.
- Counters: the rinse index is 2 bits. The LOCK/DRAIN counter is 16 bits, saturates and never wraps.
- Outputs are registered: they change only on a clock edge or on the reset assertion.

Optional Feature:
Macro SEQ_WATCHDOG_EN.
- Defined:
  - A per-phase counter clears on every timer_start and counts only while timer_enable=1.
  - If it reaches WDOG_LIMIT with no timer_done: set error=1 and go to DRAIN, as if cancel had been asserted.
- Undefined:
  - No counter is built; error stays 0 permanently.
  - WDOG_LIMIT is unused.

Test Plan:
- Normal program: mode=01, start pulse, each phase's timer_done at 20 cycles -> states 1,2,3,4,5,8,0; four timer_start pulses with phase_sel 00,01,10,11; done pulses once; door_lock=1 from LOCK until DONE.
- Heavy program: mode=10, rinse_cnt=3 -> three RINSE entries with three timer_start pulses at phase_sel=10 before SPIN. Repeat with rinse_cnt=0 -> exactly one RINSE.
- Lid pause: lid=1 for 10 cycles mid-WASH -> PAUSE (6) with timer_enable=0; on lid=0, back to WASH (3) with no timer_start pulse; a timer_done pulsed during PAUSE does not advance the state.
- Cancel: cancel=1 in RINSE -> DRAIN (7) with drain_valve=1 for exactly 8 cycles, then DONE (8), done pulse, IDLE. cancel and lid asserted in the same cycle -> DRAIN.
- Reset and interlock cases:
  - rst_n=0 mid-SPIN -> all outputs 0 and state 0 at once.
  - start with lid=1 -> stays in IDLE.
  - lid=1 during LOCK -> IDLE, door_lock=0.
- Watchdog (SEQ_WATCHDOG_EN defined, WDOG_LIMIT=64): no timer_done in WASH -> error=1 and DRAIN after 64 enabled cycles; the next accepted start clears error.
